instr_fetch: RTL and testbench

Instruction-fetch stage feeding the control unit (`CU`) and the register file. It holds the program counter and issues word reads to instruction memory through a req/ack handshake. It latches each returned word into an instruction register and presents it, with its 5-bit opcode field, to decode under a valid/ready handshake. It also applies branch redirects from downstream and stops on a HALT opcode.

---
 rtl/instr_fetch.sv | 96 +++++++++
 tb/tb_instr_fetch.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the program counter, reads instruction memory
// over a req/ack handshake, and holds one instruction for decode under a
// valid/ready handshake. Branch redirects arrive with the accepting cycle, and
// a consumed HALT opcode parks the stage until reset.
module instr_fetch #(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [4:0]        HALT_OP  = 5'b11111
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [4:0]         opcode,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               id_ready,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               halted
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    VALID  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] pc;
  logic              accept;
  logic              is_halt;

  assign opcode    = instr[INSTR_W-1 -: 5];
  assign imem_addr = pc;
  assign is_halt   = (opcode == HALT_OP);
  assign accept    = (state == VALID) & id_ready;

  // State register; reset always restarts fetching from RESET_PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and state-decoded outputs; imem_req is masked by rst so it drops the instant reset rises.
  always_comb begin
    state_next  = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    case (state)
      FETCH: begin
        imem_req = ~rst;
        if (imem_ack) begin
          state_next = VALID;
        end
      end
      VALID: begin
        instr_valid = 1'b1;
        if (id_ready) begin
          state_next = is_halt ? HALTED : FETCH;
        end
      end
      HALTED: begin
        halted = 1'b1;
      end
      default: begin
        state_next = FETCH;
      end
    endcase
  end

  // PC and instruction register: latch on ack, post-increment PC, redirect on an accepted non-HALT branch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      instr    <= '0;
      instr_pc <= '0;
    end else if ((state == FETCH) && imem_ack) begin
      instr    <= imem_rdata;
      instr_pc <= pc;
      pc       <= pc + ADDR_W'(1);
    end else if (accept && !is_halt && branch_taken) begin
      pc <= branch_target;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a behavioural model of the fetch/hold/halt rules is
// compared against the main instance every cycle, directed scenarios pin the
// model with literal expectations, and a second instance starting at 0xFFFF
// exercises PC wrap into a HALT word.
module tb_instr_fetch;
  localparam int AW = 16;
  localparam int IW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance signals (RESET_PC = 0)
  logic          rst;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack = 1'b0;
  logic [IW-1:0] imem_rdata = '0;
  logic [IW-1:0] instr;
  logic [4:0]    opcode;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic          id_ready;
  logic          branch_taken;
  logic [AW-1:0] branch_target;
  logic          halted;

  // Wrap instance signals (RESET_PC = 0xFFFF)
  logic          rst2;
  logic          imem_req2;
  logic [AW-1:0] imem_addr2;
  logic          imem_ack2 = 1'b0;
  logic [IW-1:0] imem_rdata2 = '0;
  logic [IW-1:0] instr2;
  logic [4:0]    opcode2;
  logic [AW-1:0] instr_pc2;
  logic          instr_valid2;
  logic          id_ready2;
  logic          halted2;

  int checks   = 0;
  int failures = 0;
  int lat      = 0;
  int wcnt     = 0;

  logic [IW-1:0] ovr [logic [AW-1:0]];
  logic [AW-1:0] fetch_log [$];

  instr_fetch #(.ADDR_W(AW), .INSTR_W(IW), .RESET_PC(16'h0000), .HALT_OP(5'b11111)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .opcode(opcode),
    .instr_pc(instr_pc), .instr_valid(instr_valid), .id_ready(id_ready),
    .branch_taken(branch_taken), .branch_target(branch_target), .halted(halted)
  );

  instr_fetch #(.ADDR_W(AW), .INSTR_W(IW), .RESET_PC(16'hFFFF), .HALT_OP(5'b11111)) dut2 (
    .clk(clk), .rst(rst2), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ack(imem_ack2), .imem_rdata(imem_rdata2), .instr(instr2), .opcode(opcode2),
    .instr_pc(instr_pc2), .instr_valid(instr_valid2), .id_ready(id_ready2),
    .branch_taken(1'b0), .branch_target(16'h0000), .halted(halted2)
  );

  // Memory contents: overrides first, otherwise opcode = address[3:0] (never HALT)
  function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
    if (ovr.exists(a)) return ovr[a];
    return {1'b0, a[3:0], 11'h000, a};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Main-instance memory: answers after 'lat' waiting cycles of a held request
  always @(posedge clk) begin
    #2;
    if (rst || !imem_req) begin
      imem_ack = 1'b0;
      wcnt = 0;
    end else if (wcnt >= lat) begin
      imem_ack = 1'b1;
      imem_rdata = mem_word(imem_addr);
      fetch_log.push_back(imem_addr);
    end else begin
      imem_ack = 1'b0;
      wcnt++;
    end
  end

  // Wrap-instance memory: zero latency, HALT word at address 0
  always @(posedge clk) begin
    #2;
    imem_ack2 = imem_req2;
    imem_rdata2 = (imem_addr2 == 16'h0000) ? 32'hF800_0000 : 32'h0800_FFFF;
  end

  // Behavioural model: one held instruction, a next-fetch address, and a done flag
  logic          m_hold;
  logic          m_done;
  logic [AW-1:0] m_next;
  logic [AW-1:0] m_ipc;
  logic [IW-1:0] m_instr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hold  <= 1'b0;
      m_done  <= 1'b0;
      m_next  <= 16'h0000;
      m_ipc   <= 16'h0000;
      m_instr <= '0;
    end else if (m_done) begin
      m_done <= 1'b1;
    end else if (m_hold) begin
      if (id_ready) begin
        if (m_instr[IW-1 -: 5] == 5'h1F) begin
          m_done <= 1'b1;
        end else begin
          m_hold <= 1'b0;
          if (branch_taken) m_next <= branch_target;
        end
      end
    end else if (imem_ack) begin
      m_hold  <= 1'b1;
      m_instr <= imem_rdata;
      m_ipc   <= m_next;
      m_next  <= m_next + 16'd1;
    end
  end

  // Per-cycle comparison of the main instance against the model
  always @(negedge clk) begin
    logic exp_req;
    exp_req = !rst && !m_hold && !m_done;
    checkOutput("m_imem_req", imem_req, exp_req);
    if (exp_req) checkOutput("m_imem_addr", imem_addr, m_next);
    checkOutput("m_instr_valid", instr_valid, m_hold && !m_done);
    checkOutput("m_halted", halted, m_done);
    checkOutput("m_instr", instr, m_instr);
    checkOutput("m_opcode", opcode, m_instr[IW-1 -: 5]);
    checkOutput("m_instr_pc", instr_pc, m_ipc);
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cnt;
    int bad;
    logic stable;
    rst = 1'b1; id_ready = 1'b0; branch_taken = 1'b0; branch_target = '0;
    rst2 = 1'b1; id_ready2 = 1'b0;
    ovr[16'h0000] = 32'h0800_0000;
    ovr[16'h0042] = 32'hF800_0042;

    // Reset state
    tick(2);
    checkOutput("rst_req", imem_req, 0);
    checkOutput("rst_valid", instr_valid, 0);
    checkOutput("rst_halted", halted, 0);
    checkOutput("rst_instr", instr, 0);
    checkOutput("rst_instr_pc", instr_pc, 0);
    rst = 1'b0;

    // First fetch with ack in the first FETCH cycle
    tick(1);
    checkOutput("first_req", imem_req, 1);
    checkOutput("first_addr", imem_addr, 16'h0000);
    tick(1);
    checkOutput("first_valid", instr_valid, 1);
    checkOutput("first_opcode", opcode, 5'b00001);
    checkOutput("first_instr_pc", instr_pc, 0);
    checkOutput("first_instr", instr, 32'h0800_0000);
    id_ready = 1'b1; tick(1); id_ready = 1'b0;
    checkOutput("second_addr", imem_addr, 16'h0001);
    checkOutput("second_req", imem_req, 1);
    tick(1);

    // Backpressure, with a branch request that must be ignored without accept
    branch_taken = 1'b1; branch_target = 16'h1234; lat = 3;
    tick(5);
    checkOutput("bp_valid", instr_valid, 1);
    checkOutput("bp_instr_pc", instr_pc, 16'h0001);
    checkOutput("bp_instr", instr, 32'h0800_0001);
    checkOutput("bp_req", imem_req, 0);
    branch_taken = 1'b0;
    id_ready = 1'b1; tick(1); id_ready = 1'b0;

    // Variable latency: request held for 4 cycles on address 2
    cnt = 0; stable = 1'b1;
    for (int i = 0; i < 20 && !instr_valid; i++) begin
      if (imem_req) begin
        cnt++;
        if (imem_addr !== 16'h0002) stable = 1'b0;
      end
      tick(1);
    end
    checkOutput("lat_req_cycles", cnt, 4);
    checkOutput("lat_addr_stable", stable, 1);
    checkOutput("lat_instr_pc", instr_pc, 16'h0002);
    lat = 0;

    // Walk to pc 5 and branch to 0x0040
    for (int i = 0; i < 40 && !(instr_valid && instr_pc == 16'h0005); i++) begin
      if (instr_valid) begin id_ready = 1'b1; tick(1); id_ready = 1'b0; end
      else tick(1);
    end
    checkOutput("br_at_pc5", instr_pc, 16'h0005);
    id_ready = 1'b1; branch_taken = 1'b1; branch_target = 16'h0040;
    tick(1);
    id_ready = 1'b0; branch_taken = 1'b0;
    checkOutput("br_addr", imem_addr, 16'h0040);
    checkOutput("br_req", imem_req, 1);
    tick(1);
    checkOutput("br_instr_pc", instr_pc, 16'h0040);
    bad = 0;
    foreach (fetch_log[k]) if (fetch_log[k] >= 16'h0006 && fetch_log[k] < 16'h0040) bad++;
    checkOutput("br_no_wrong_path", bad, 0);

    // HALT at 0x0042 accepted with a branch that must be ignored
    for (int i = 0; i < 40 && !(instr_valid && instr_pc == 16'h0042); i++) begin
      if (instr_valid) begin id_ready = 1'b1; tick(1); id_ready = 1'b0; end
      else tick(1);
    end
    checkOutput("halt_opcode", opcode, 5'h1F);
    id_ready = 1'b1; branch_taken = 1'b1; branch_target = 16'h0010;
    tick(1);
    id_ready = 1'b0; branch_taken = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (!halted || imem_req || instr_valid) bad++;
      tick(1);
    end
    checkOutput("halt_hold", bad, 0);
    checkOutput("halt_instr", instr, 32'hF800_0042);

    // Reset out of HALTED, then an async reset in the middle of a slow fetch
    lat = 5;
    rst = 1'b1; #1;
    checkOutput("halt_rst_halted", halted, 0);
    checkOutput("halt_rst_req", imem_req, 0);
    tick(1); rst = 1'b0; tick(1);
    checkOutput("restart_addr", imem_addr, 16'h0000);
    checkOutput("restart_req", imem_req, 1);
    tick(1);
    rst = 1'b1; #1;
    checkOutput("midfetch_req", imem_req, 0);
    tick(1); rst = 1'b0; tick(1);
    checkOutput("post_rst_addr", imem_addr, 16'h0000);
    checkOutput("post_rst_req", imem_req, 1);
    for (int i = 0; i < 20 && !instr_valid; i++) tick(1);
    checkOutput("post_rst_valid", instr_valid, 1);
    checkOutput("post_rst_instr", instr, 32'h0800_0000);
    checkOutput("post_rst_pc", instr_pc, 16'h0000);

    // PC wrap from 0xFFFF into a HALT word at 0x0000
    tick(1); rst2 = 1'b0; tick(1);
    checkOutput("wrap_first_addr", imem_addr2, 16'hFFFF);
    checkOutput("wrap_first_req", imem_req2, 1);
    tick(1);
    checkOutput("wrap_first_valid", instr_valid2, 1);
    checkOutput("wrap_first_pc", instr_pc2, 16'hFFFF);
    id_ready2 = 1'b1; tick(1);
    checkOutput("wrap_second_addr", imem_addr2, 16'h0000);
    checkOutput("wrap_second_req", imem_req2, 1);
    tick(1);
    checkOutput("wrap_halt_opcode", opcode2, 5'h1F);
    checkOutput("wrap_halt_pc", instr_pc2, 16'h0000);
    checkOutput("wrap_not_yet_halted", halted2, 0);
    tick(1);
    id_ready2 = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (!halted2 || imem_req2 || instr_valid2) bad++;
      tick(1);
    end
    checkOutput("wrap_halt_hold", bad, 0);
    checkOutput("wrap_halt_instr", instr2, 32'hF800_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
